// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared constants and types for the sequential multiply/divide unit.
//   - state_e     : FSM encoding (IDLE/CALC/FIX/DONE)
//   - WIDTH       : operand/result width (32 only)
//   - ITER_COUNT  : Booth / restoring iterations per operation
//   - OP_MULT/DIV : latched operation select
//   - abs_val     : two's-complement magnitude helper for divide operands
package mult_div_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ITER_COUNT = 32;
  localparam logic [5:0]  ITER_LAST  = 6'(ITER_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // 0x80000000 maps to itself, which reads correctly as 2^31 unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// div_step: one combinational restoring-division step on magnitudes.
//   rem_i     : partial remainder before the step
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after the step
//   q_o       : quotient bit produced by this step
module div_step
  import mult_div_pkg::*;
(
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, divisor_i});
    // When the trial succeeds the true difference is below the divisor,
    // so the low WIDTH bits of the modular subtraction are exact.
    diff    = shifted[WIDTH-1:0] - divisor_i;
    rem_o   = q_o ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed 32x32 multiplier (radix-2 Booth) and
// 32/32 divider (restoring, truncation toward zero) loading HI/LO.
//   clk, reset            : clock, asynchronous active-high reset
//   start_mult, start_div : one-cycle start strobes (multiply wins if both)
//   a_in, b_in            : operands, latched on the accepting edge
//   hi, lo                : result registers, updated only on entry to DONE
//   busy                  : FSM not idle
//   done                  : one-cycle result-ready pulse
//   div0                  : divide-by-zero pulse alongside done
// Build option MULT_DIV_DIV0_EXC_EN: divide by zero short-circuits to DONE
// with div0 set and hi/lo unchanged; otherwise div0 is tied low and the
// divide runs its full length.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);
  import mult_div_pkg::*;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             op_q, op_d;
  // p: Booth partial product (extra sign bit) or divide partial remainder.
  // m: Booth multiplier/product-low or divide dividend/quotient shifter.
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] div_rem;
  logic             div_q;

  div_step u_div_step (
    .rem_i     (p_q[WIDTH-1:0]),
    .bit_i     (m_q[WIDTH-1]),
    .divisor_i (mcand_q),
    .rem_o     (div_rem),
    .q_o       (div_q)
  );

  always_comb begin
    unique case ({m_q[0], qm1_q})
      2'b01:   booth_sum = p_q + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   booth_sum = p_q - {mcand_q[WIDTH-1], mcand_q};
      default: booth_sum = p_q;
    endcase
  end

`ifdef MULT_DIV_DIV0_EXC_EN
  logic div0_q, div0_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    p_d     = p_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULT_DIV_DIV0_EXC_EN
    div0_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          op_d    = OP_MULT;
          p_d     = '0;
          m_d     = b_in;
          qm1_d   = 1'b0;
          mcand_d = a_in;
          cnt_d   = '0;
          state_d = CALC;
        end else if (start_div) begin
`ifdef MULT_DIV_DIV0_EXC_EN
          if (b_in == '0) begin
            div0_d  = 1'b1;
            state_d = DONE;
          end else
`endif
          begin
            op_d    = OP_DIV;
            p_d     = '0;
            m_d     = abs_val(a_in);
            qm1_d   = 1'b0;
            mcand_d = abs_val(b_in);
            negq_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            negr_d  = a_in[WIDTH-1];
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q == ITER_LAST) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (op_q == OP_MULT) begin
            // Arithmetic right shift of {P, multiplier, q-1}.
            p_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            m_d   = {booth_sum[0], m_q[WIDTH-1:1]};
            qm1_d = m_q[0];
          end else begin
            p_d = {1'b0, div_rem};
            m_d = {m_q[WIDTH-2:0], div_q};
          end
        end
      end
      FIX: begin
        state_d = DONE;
        if (op_q == OP_MULT) begin
          hi_d = p_q[WIDTH-1:0];
          lo_d = m_q;
        end else begin
          lo_d = negq_q ? (~m_q + 1'b1) : m_q;
          hi_d = negr_q ? (~p_q[WIDTH-1:0] + 1'b1) : p_q[WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      p_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      p_q     <= p_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef MULT_DIV_DIV0_EXC_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div0_q <= 1'b0;
    else       div0_q <= div0_d;
  end
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div0;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a_in(a_in), .b_in(b_in), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference results straight from signed arithmetic.
  function automatic void calc(input bit mul, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, pr, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (mul) begin
      pr = sa * sb;
      h = pr[63:32];
      l = pr[31:0];
    end else if (b == 32'h0) begin
      h = a;
      l = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
    end else begin
      q = sa / sb;
      r = sa % sb;
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  // Model: m_cnt = edges elapsed since the accepting edge (0 = idle).
  // Done is visible after 35 edges (start edge + 34), idle after the next.
  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_div0 = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    end else begin
      m_div0 = 1'b0;
      if (m_cnt == 35) m_cnt = 0;
      else if (m_cnt != 0) begin
        m_cnt++;
        if (m_cnt == 35) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (start_mult || start_div) begin
`ifdef MULT_DIV_DIV0_EXC_EN
        if (!start_mult && b_in == 32'h0) begin
          m_cnt = 35; m_div0 = 1'b1;
        end else
`endif
        begin
          calc(start_mult, a_in, b_in, p_hi, p_lo);
          m_cnt = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_cnt != 0});
    chk("done", {31'b0, done}, {31'b0, m_cnt == 35});
    chk("div0", {31'b0, div0}, {31'b0, m_div0});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic do_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b,
                       input bit lit, input logic [31:0] eh, input logic [31:0] el,
                       input int elat, input string nm);
    int lat;
    @(negedge clk);
    start_mult = mul; start_div = dv; a_in = a; b_in = b;
    @(negedge clk);
    start_mult = 1'b0; start_div = 1'b0; a_in = $urandom; b_in = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_done_seen"}, {31'b0, done}, 32'd1);
    if (lit) begin
      chk({nm, "_latency"}, 32'(lat - 1), 32'(elat));
      chk({nm, "_hi"}, hi, eh);
      chk({nm, "_lo"}, lo, el);
    end
  endtask

  logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int lat;
    #1 reset = 1'b1;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_op(1, 0, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, "mul_7x-3");
    do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0, 34, "mul_min2");
    do_op(0, 1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, "div_-7/2");
`ifdef MULT_DIV_DIV0_EXC_EN
    do_op(0, 1, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_by0");
`else
    do_op(0, 1, 32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF, 34, "div_by0");
`endif
    do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 34, "div_ovf");

    // Both strobes together: multiply wins; later strobes while busy are dropped.
    @(negedge clk);
    start_mult = 1'b1; start_div = 1'b1; a_in = 32'd6; b_in = 32'd4;
    @(negedge clk);
    start_mult = 1'b0; start_div = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      if (lat == 5) begin start_div = 1'b1; a_in = 32'd9; b_in = 32'd3; end
      else start_div = 1'b0;
      @(negedge clk);
      lat++;
    end
    start_div = 1'b0;
    chk("both_latency", 32'(lat - 1), 32'd34);
    chk("both_hi", hi, 32'd0);
    chk("both_lo", lo, 32'd24);
    start_mult = 1'b1; a_in = 32'd5; b_in = 32'd5;
    @(negedge clk);
    start_mult = 1'b0;
    chk("start_in_done_ignored", {31'b0, busy}, 32'd0);

    // Reset mid-multiply.
    @(negedge clk);
    start_mult = 1'b1; a_in = 32'h1234_5678; b_in = 32'h0000_0100;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    do_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0, 32'h1, 34, "after_reset");

    for (int i = 0; i < 40; i++) begin
      bit mul, dv;
      mul = ($urandom_range(0, 1) == 1);
      dv  = !mul || ($urandom_range(0, 3) == 0);
      do_op(mul, dv, pick(), pick(), 0, 32'h0, 32'h0, 0, "rand");
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
